// File: rtl/counter_seq_ctrl.sv
// Configurable up-counter sequencer: takes limit/prescale/mode over valid/ready,
// counts with a prescaled strobe, wraps at limit and emits a registered terminal tick.
module counter_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic [PRE_W-1:0] cfg_prescale,
  input  logic             cfg_periodic,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] count_r, count_s;
  logic [PRE_W-1:0] pre_r, pre_s;
  logic [WIDTH-1:0] limit_r, limit_s;
  logic [PRE_W-1:0] prescale_r, prescale_s;
  logic             periodic_r, periodic_s;
  logic             tick_r, tick_s;
  logic             done_r;
  logic             cfg_xfer_s;
  logic             strobe_s;
  logic             at_limit_s;

  assign cfg_ready  = (state_r != ST_RUN);
  assign busy       = (state_r == ST_RUN);
  assign count      = count_r;
  assign tick       = tick_r;
  assign done       = done_r;

  assign cfg_xfer_s = cfg_valid & cfg_ready;
  assign strobe_s   = (pre_r == prescale_r);
  assign at_limit_s = (count_r == limit_r);

  // Next-state, counter and config-capture decode
  always_comb begin
    state_s    = state_r;
    count_s    = count_r;
    pre_s      = pre_r;
    limit_s    = limit_r;
    prescale_s = prescale_r;
    periodic_s = periodic_r;
    tick_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cfg_xfer_s) begin
          state_s    = ST_ARMED;
          limit_s    = cfg_limit;
          prescale_s = cfg_prescale;
          periodic_s = cfg_periodic;
          count_s    = {WIDTH{1'b0}};
          pre_s      = {PRE_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ARMED, ST_DONE: begin
        // A config transfer wins over a coincident start
        if (cfg_xfer_s) begin
          state_s    = ST_ARMED;
          limit_s    = cfg_limit;
          prescale_s = cfg_prescale;
          periodic_s = cfg_periodic;
          count_s    = {WIDTH{1'b0}};
          pre_s      = {PRE_W{1'b0}};
        end else if (start) begin
          state_s = ST_RUN;
          count_s = {WIDTH{1'b0}};
          pre_s   = {PRE_W{1'b0}};
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_s = ST_ARMED;
          count_s = {WIDTH{1'b0}};
          pre_s   = {PRE_W{1'b0}};
        end else if (strobe_s) begin
          pre_s = {PRE_W{1'b0}};
          if (at_limit_s) begin
            tick_s  = 1'b1;
            count_s = {WIDTH{1'b0}};
            if (periodic_r) begin
              state_s = ST_RUN;
            end else begin
              state_s = ST_DONE;
            end
          end else begin
            count_s = count_r + WIDTH'(1);
          end
        end else begin
          pre_s = pre_r + PRE_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        count_s = {WIDTH{1'b0}};
        pre_s   = {PRE_W{1'b0}};
      end
    endcase
  end

  // State, datapath and registered output update
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      count_r    <= {WIDTH{1'b0}};
      pre_r      <= {PRE_W{1'b0}};
      limit_r    <= {WIDTH{1'b0}};
      prescale_r <= {PRE_W{1'b0}};
      periodic_r <= 1'b0;
      tick_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      pre_r      <= pre_s;
      limit_r    <= limit_s;
      prescale_r <= prescale_s;
      periodic_r <= periodic_s;
      tick_r     <= tick_s;
      done_r     <= (state_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl: stimulus queues expected per-cycle snapshots
// and tick cycles; a negedge monitor pops and compares them against the DUT.
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_limit;
  logic [3:0] cfg_prescale;
  logic       cfg_periodic;
  logic       start;
  logic       stop;
  logic [7:0] count;
  logic       tick;
  logic       busy;
  logic       done;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         at;
    logic [7:0] cnt;
    logic       tk;
    logic       bz;
    logic       dn;
    logic       rdy;
    string      nm;
  } snap_t;

  snap_t sq[$];
  int    tq[$];

  counter_seq_ctrl #(.WIDTH(8), .PRE_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_limit    (cfg_limit),
    .cfg_prescale (cfg_prescale),
    .cfg_periodic (cfg_periodic),
    .start        (start),
    .stop         (stop),
    .count        (count),
    .tick         (tick),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares queued snapshots and tick events at the falling edge
  always @(negedge clk) begin : monitor
    snap_t s;
    while (sq.size() > 0 && sq[0].at <= cyc) begin
      s = sq.pop_front();
      checks++;
      if (s.at != cyc || count !== s.cnt || tick !== s.tk || busy !== s.bz ||
          done !== s.dn || cfg_ready !== s.rdy) begin
        errors++;
        $display("FAIL %s cyc=%0d (due %0d): got count=%0d tick=%b busy=%b done=%b cfg_ready=%b, expected count=%0d tick=%b busy=%b done=%b cfg_ready=%b",
                 s.nm, cyc, s.at, count, tick, busy, done, cfg_ready,
                 s.cnt, s.tk, s.bz, s.dn, s.rdy);
      end
    end
    if (tick === 1'b1) begin
      checks++;
      if (tq.size() > 0 && tq[0] == cyc) begin
        void'(tq.pop_front());
      end else begin
        errors++;
        $display("FAIL unexpected_tick cyc=%0d: got tick=1, expected no tick", cyc);
      end
    end
    while (tq.size() > 0 && tq[0] < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_tick cyc=%0d: got no tick, expected tick at cyc %0d", cyc, tq[0]);
      void'(tq.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp(input int at, input int cnt, input logic tk, input logic bz,
                     input logic dn, input logic rdy, input string nm);
    snap_t s;
    s.at  = at;
    s.cnt = 8'(cnt);
    s.tk  = tk;
    s.bz  = bz;
    s.dn  = dn;
    s.rdy = rdy;
    s.nm  = nm;
    sq.push_back(s);
  endtask

  task automatic do_cfg(input int lim, input int pre, input logic per);
    cfg_limit    = 8'(lim);
    cfg_prescale = 4'(pre);
    cfg_periodic = per;
    cfg_valid    = 1'b1;
    step(1);
    cfg_valid    = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin : stimulus
    int a;
    int b;
    rst = 1'b1; cfg_valid = 1'b0; cfg_limit = 8'd0; cfg_prescale = 4'd0;
    cfg_periodic = 1'b0; start = 1'b0; stop = 1'b0;
    step(2);
    exp(cyc, 0, 1'b0, 1'b0, 1'b0, 1'b1, "reset_state");
    rst = 1'b0;

    // 1: reset mid-run, three cycles in
    do_cfg(5, 0, 1'b0);
    a = cyc;
    do_start();
    exp(a + 3, 2, 1'b0, 1'b1, 1'b0, 1'b0, "t1_run");
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    exp(a + 4, 0, 1'b0, 1'b0, 1'b0, 1'b1, "t1_reset");

    // 2: periodic limit=3 pre=0, then stop on a terminal strobe
    do_cfg(3, 0, 1'b1);
    a = cyc;
    do_start();
    for (int j = 0; j < 12; j++)
      exp(a + 1 + j, j % 4, (j > 0 && j % 4 == 0), 1'b1, 1'b0, 1'b0, "t2_seq");
    tq.push_back(a + 5);
    tq.push_back(a + 9);
    step(11);
    do_stop();
    exp(a + 13, 0, 1'b0, 1'b0, 1'b0, 1'b1, "t2_stop");

    // 3: one-shot limit=2 pre=1, then rerun from DONE
    do_cfg(2, 1, 1'b0);
    for (int r = 0; r < 2; r++) begin
      a = cyc;
      do_start();
      for (int j = 0; j < 6; j++)
        exp(a + 1 + j, j / 2, 1'b0, 1'b1, 1'b0, 1'b0, "t3_seq");
      exp(a + 7, 0, 1'b1, 1'b0, 1'b1, 1'b1, "t3_done");
      exp(a + 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, "t3_hold");
      tq.push_back(a + 7);
      step(7);
    end

    // 4: config from DONE, then stop coincident with terminal strobe
    exp(cyc + 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, "t4_armed");
    do_cfg(1, 0, 1'b0);
    a = cyc;
    do_start();
    exp(a + 2, 1, 1'b0, 1'b1, 1'b0, 1'b0, "t4_cnt1");
    exp(a + 3, 0, 1'b0, 1'b0, 1'b0, 1'b1, "t4_stop");
    step(1);
    do_stop();

    // 5: cfg_valid and start held during RUN are ignored
    do_cfg(3, 0, 1'b1);
    a = cyc;
    do_start();
    for (int j = 0; j < 8; j++)
      exp(a + 1 + j, j % 4, (j == 4), 1'b1, 1'b0, 1'b0, "t5_locked");
    tq.push_back(a + 5);
    cfg_valid = 1'b1; cfg_limit = 8'd7; cfg_prescale = 4'd2; cfg_periodic = 1'b0;
    start = 1'b1;
    step(6);
    cfg_valid = 1'b0;
    start = 1'b0;
    step(1);
    do_stop();
    exp(a + 9, 0, 1'b0, 1'b0, 1'b0, 1'b1, "t5_stop");
    b = cyc;
    do_start();
    for (int j = 0; j < 5; j++)
      exp(b + 1 + j, j % 4, (j == 4), 1'b1, 1'b0, 1'b0, "t5_cfg_kept");
    tq.push_back(b + 5);
    step(4);
    do_stop();
    exp(b + 6, 0, 1'b0, 1'b0, 1'b0, 1'b1, "t5_stop2");
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    a = cyc;
    for (int j = 0; j < 4; j++)
      exp(a + j, 0, 1'b0, 1'b0, 1'b0, 1'b1, "t5_idle_start");
    do_start();
    step(2);

    // 6a: limit=0 pre=3 periodic
    do_cfg(0, 3, 1'b1);
    a = cyc;
    do_start();
    for (int j = 0; j < 13; j++)
      exp(a + 1 + j, 0, (j > 0 && j % 4 == 0), 1'b1, 1'b0, 1'b0, "t6_lim0");
    tq.push_back(a + 5);
    tq.push_back(a + 9);
    tq.push_back(a + 13);
    step(12);
    do_stop();
    exp(a + 14, 0, 1'b0, 1'b0, 1'b0, 1'b1, "t6_lim0_stop");

    // 6b: full-range wrap, limit=255 pre=0
    do_cfg(255, 0, 1'b1);
    a = cyc;
    do_start();
    exp(a + 128, 127, 1'b0, 1'b1, 1'b0, 1'b0, "t6_mid");
    exp(a + 256, 255, 1'b0, 1'b1, 1'b0, 1'b0, "t6_max");
    exp(a + 257, 0, 1'b1, 1'b1, 1'b0, 1'b0, "t6_wrap1");
    exp(a + 258, 1, 1'b0, 1'b1, 1'b0, 1'b0, "t6_after");
    exp(a + 512, 255, 1'b0, 1'b1, 1'b0, 1'b0, "t6_max2");
    exp(a + 513, 0, 1'b1, 1'b1, 1'b0, 1'b0, "t6_wrap2");
    tq.push_back(a + 257);
    tq.push_back(a + 513);
    step(513);
    do_stop();
    exp(a + 515, 0, 1'b0, 1'b0, 1'b0, 1'b1, "t6_stop");
    step(3);

    while (sq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL unchecked_%s: got no sample, expected check at cyc %0d", sq[0].nm, sq[0].at);
      void'(sq.pop_front());
    end
    while (tq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL pending_tick: got no tick, expected tick at cyc %0d", tq[0]);
      void'(tq.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
